soc_wb_interconnect: RTL

- Parametrised 1-master / N-slave Wishbone (classic, single-beat) interconnect between the CPU external bus and the SoC peripherals (audio IP and the ones added after it).
- Replaces the current point-to-point CPU-to-audio bus connection.
- Adds address decoding, per-slave select, bus-error generation for unmapped addresses, a watchdog timeout, and abort handling when the master drops cyc.
- Sits in the SoC top between the CPU wrapper and the peripheral instances.

---
 rtl/soc_bus_pkg.sv | 23 ++
 rtl/soc_wb_interconnect_if.sv | 51 +++++
 rtl/soc_wb_addr_decode.sv | 28 ++
 rtl/soc_wb_interconnect.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/soc_bus_pkg.sv
// Shared SoC bus definitions: error cause codes, interconnect FSM states and
// the default peripheral address map.
package soc_bus_pkg;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_DECODE  = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_SLAVE   = 2'd3;

   localparam logic [31:0] AUDIO_BASE = 32'hF000_0000;
   localparam logic [31:0] AUDIO_MASK = 32'hFFFF_0000;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StResp
   } wb_state_e;

   function automatic int unsigned cnt_width(input int unsigned timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/soc_wb_interconnect_if.sv
// Bus bundle of the 1-master / N-slave Wishbone interconnect: CPU-side and
// peripheral-side signals plus the error status outputs.
interface soc_wb_interconnect_if #(
   parameter int unsigned N_SLAVES = 2,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32
);
   localparam int unsigned SEL_W = DATA_W / 8;

   logic [ADDR_W-1:0]          m_adr_i;
   logic [DATA_W-1:0]          m_dat_i;
   logic [DATA_W-1:0]          m_dat_o;
   logic                       m_we_i;
   logic [SEL_W-1:0]           m_sel_i;
   logic                       m_stb_i;
   logic                       m_cyc_i;
   logic                       m_ack_o;
   logic                       m_err_o;

   logic [N_SLAVES*ADDR_W-1:0] s_adr_o;
   logic [N_SLAVES*DATA_W-1:0] s_dat_o;
   logic [N_SLAVES*DATA_W-1:0] s_dat_i;
   logic [N_SLAVES-1:0]        s_we_o;
   logic [N_SLAVES*SEL_W-1:0]  s_sel_o;
   logic [N_SLAVES-1:0]        s_stb_o;
   logic [N_SLAVES-1:0]        s_cyc_o;
   logic [N_SLAVES-1:0]        s_ack_i;
   logic [N_SLAVES-1:0]        s_err_i;

   logic [ADDR_W-1:0]          err_adr_o;
   logic [1:0]                 err_code_o;

   // Interconnect view: it is the slave of the CPU bus.
   modport slave (
      input  m_adr_i, m_dat_i, m_we_i, m_sel_i, m_stb_i, m_cyc_i,
      output m_dat_o, m_ack_o, m_err_o,
      output s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o,
      input  s_dat_i, s_ack_i, s_err_i,
      output err_adr_o, err_code_o
   );

   // Environment view: CPU master plus the peripheral responders.
   modport master (
      output m_adr_i, m_dat_i, m_we_i, m_sel_i, m_stb_i, m_cyc_i,
      input  m_dat_o, m_ack_o, m_err_o,
      input  s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o,
      output s_dat_i, s_ack_i, s_err_i,
      input  err_adr_o, err_code_o
   );

endinterface

// File: rtl/soc_wb_addr_decode.sv
// Combinational base/mask address decoder; the lowest matching slave index
// wins when ranges overlap.
module soc_wb_addr_decode #(
   parameter int unsigned                N_SLAVES = 2,
   parameter int unsigned                ADDR_W   = 32,
   parameter int unsigned                IDX_W    = 1,
   parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE = '0,
   parameter logic [N_SLAVES*ADDR_W-1:0] SLV_MASK = '0
) (
   input  logic [ADDR_W-1:0] i_adr,
   output logic              o_hit,
   output logic [IDX_W-1:0]  o_idx
);

   always_comb begin
      o_hit = 1'b0;
      o_idx = '0;
      // Scan high-to-low so the lowest matching index is the last one written.
      for (int i = N_SLAVES - 1; i >= 0; i--) begin
         if ((i_adr & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
             (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W])) begin
            o_hit = 1'b1;
            o_idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/soc_wb_interconnect.sv
// 1-master / N-slave classic Wishbone interconnect with address decode,
// decode-miss / timeout / slave bus errors and master abort handling.
module soc_wb_interconnect
   import soc_bus_pkg::*;
#(
   parameter int unsigned                N_SLAVES = 2,
   parameter int unsigned                ADDR_W   = 32,
   parameter int unsigned                DATA_W   = 32,
   parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE = {32'hF001_0000, AUDIO_BASE},
   parameter logic [N_SLAVES*ADDR_W-1:0] SLV_MASK = {32'hFFFF_0000, AUDIO_MASK},
   parameter int unsigned                TIMEOUT  = 255
) (
   input logic                  clk,
   input logic                  arstn,
   soc_wb_interconnect_if.slave bus
);

   localparam int unsigned     SEL_W    = DATA_W / 8;
   localparam int unsigned     IDX_W    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
   localparam int unsigned     CNT_W    = cnt_width(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   wb_state_e          r_state, w_state;
   logic [ADDR_W-1:0]  r_adr, w_adr;
   logic [DATA_W-1:0]  r_dat, w_dat;
   logic               r_we, w_we;
   logic [SEL_W-1:0]   r_sel, w_sel;
   logic [IDX_W-1:0]   r_idx, w_idx;
   logic [CNT_W-1:0]   r_cnt, w_cnt;
   logic               r_ack, w_ack;
   logic               r_err, w_err;
   logic [DATA_W-1:0]  r_rdat, w_rdat;
   logic [ADDR_W-1:0]  r_err_adr, w_err_adr;
   logic [1:0]         r_err_code, w_err_code;

   logic               w_dec_hit;
   logic [IDX_W-1:0]   w_dec_idx;
   logic               w_slv_ack;
   logic               w_slv_err;
   logic [N_SLAVES-1:0] w_slv_sel;

   soc_wb_addr_decode #(
      .N_SLAVES (N_SLAVES),
      .ADDR_W   (ADDR_W),
      .IDX_W    (IDX_W),
      .SLV_BASE (SLV_BASE),
      .SLV_MASK (SLV_MASK)
   ) u_decode (
      .i_adr (bus.m_adr_i),
      .o_hit (w_dec_hit),
      .o_idx (w_dec_idx)
   );

   assign w_slv_ack = bus.s_ack_i[r_idx];
   assign w_slv_err = bus.s_err_i[r_idx];

   always_comb begin
      w_state    = r_state;
      w_adr      = r_adr;
      w_dat      = r_dat;
      w_we       = r_we;
      w_sel      = r_sel;
      w_idx      = r_idx;
      w_cnt      = r_cnt;
      w_ack      = 1'b0;
      w_err      = 1'b0;
      w_rdat     = r_rdat;
      w_err_adr  = r_err_adr;
      w_err_code = r_err_code;
      unique case (r_state)
         StIdle: begin
            if (bus.m_cyc_i && bus.m_stb_i) begin
               w_adr = bus.m_adr_i;
               w_dat = bus.m_dat_i;
               w_we  = bus.m_we_i;
               w_sel = bus.m_sel_i;
               w_idx = w_dec_idx;
               if (w_dec_hit) begin
                  w_state = StBusy;
                  w_cnt   = '0;
               end else begin
                  w_state    = StResp;
                  w_err      = 1'b1;
                  w_err_code = ERR_DECODE;
                  w_err_adr  = bus.m_adr_i;
               end
            end
         end
         StBusy: begin
            // Abort outranks any response arriving in the same cycle.
            if (!bus.m_cyc_i) begin
               w_state = StIdle;
            end else if (w_slv_err) begin
               w_state    = StResp;
               w_err      = 1'b1;
               w_err_code = ERR_SLAVE;
               w_err_adr  = r_adr;
            end else if (w_slv_ack) begin
               w_state = StResp;
               w_ack   = 1'b1;
               if (!r_we) begin
                  w_rdat = bus.s_dat_i[r_idx*DATA_W +: DATA_W];
               end
            end else if (r_cnt == CNT_LAST) begin
               w_state    = StResp;
               w_err      = 1'b1;
               w_err_code = ERR_TIMEOUT;
               w_err_adr  = r_adr;
            end else if (r_cnt != CNT_MAX) begin
               w_cnt = r_cnt + 1'b1;
            end
         end
         StResp: w_state = StIdle;
         default: w_state = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         r_state    <= StIdle;
         r_adr      <= '0;
         r_dat      <= '0;
         r_we       <= 1'b0;
         r_sel      <= '0;
         r_idx      <= '0;
         r_cnt      <= '0;
         r_ack      <= 1'b0;
         r_err      <= 1'b0;
         r_rdat     <= '0;
         r_err_adr  <= '0;
         r_err_code <= ERR_NONE;
      end else begin
         r_state    <= w_state;
         r_adr      <= w_adr;
         r_dat      <= w_dat;
         r_we       <= w_we;
         r_sel      <= w_sel;
         r_idx      <= w_idx;
         r_cnt      <= w_cnt;
         r_ack      <= w_ack;
         r_err      <= w_err;
         r_rdat     <= w_rdat;
         r_err_adr  <= w_err_adr;
         r_err_code <= w_err_code;
      end
   end

   assign w_slv_sel = (r_state == StBusy) ? (N_SLAVES'(1) << r_idx) : '0;

   for (genvar g = 0; g < N_SLAVES; g++) begin : g_slv
      assign bus.s_adr_o[g*ADDR_W +: ADDR_W] = r_adr;
      assign bus.s_dat_o[g*DATA_W +: DATA_W] = r_dat;
      assign bus.s_sel_o[g*SEL_W +: SEL_W]   = r_sel;
   end

   assign bus.s_we_o     = {N_SLAVES{r_we}};
   assign bus.s_stb_o    = w_slv_sel;
   assign bus.s_cyc_o    = w_slv_sel;
   assign bus.m_ack_o    = r_ack;
   assign bus.m_err_o    = r_err;
   assign bus.m_dat_o    = r_rdat;
   assign bus.err_adr_o  = r_err_adr;
   assign bus.err_code_o = r_err_code;

endmodule
